result_reader: RTL and testbench

RESULT_READER -- requirements
Module: result_reader

---
 rtl/result_reader_pkg.sv | 7 +
 rtl/result_reader.sv | 95 +++++++++
 tb/tb_result_reader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/result_reader_pkg.sv
// result_reader_pkg: shared state encoding and record layout for the result readback engine
package result_reader_pkg;
  typedef enum logic [2:0] {IDLE, RD_HI, RD_LO, CHECK, PUSH, FIN} state_t;
  localparam logic [7:0] META_RUN = 8'b1000_0000;
  localparam int FAIL_BIT = 0;
  localparam int RECORD_WORDS = 2;
endpackage

// File: rtl/result_reader.sv
// result_reader: walks two-word result records in memory and pushes {fail, result_vector} into an output fifo
module result_reader
  import result_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int RTF_WIDTH = 24,
  parameter int CNT_WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [CNT_WIDTH-1:0]    max_records,
  output logic                    busy,
  output logic                    done,
  output logic                    end_marker,
  output logic [CNT_WIDTH-1:0]    record_count,
  output logic [CNT_WIDTH-1:0]    fail_count,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH/8-1:0] mem_byteenable,
  output logic                    mem_read,
  input  logic [DATA_WIDTH-1:0]   mem_readdata,
  input  logic                    mem_waitrequest,
  output logic [RTF_WIDTH:0]      ofifo_data,
  output logic                    ofifo_wrreq,
  input  logic                    ofifo_full
);
  state_t state;
  logic [ADDR_WIDTH-1:0] address;
  logic [RECORD_WORDS-1:0][DATA_WIDTH-1:0] words;
  logic [CNT_WIDTH-1:0] max_lat;
  logic rd_done, run, fail;
  assign mem_read = state == RD_HI || state == RD_LO;
  assign rd_done = mem_read && !mem_waitrequest;
  assign run = |(words[1][7:0] & META_RUN);
  assign fail = words[1][FAIL_BIT];
  // abort wins over a same-cycle push so no record escapes once abort is seen
  assign ofifo_wrreq = state == PUSH && !ofifo_full && !abort;
  assign ofifo_data = {fail, words[0], words[1][DATA_WIDTH-1:DATA_WIDTH/2]};
  assign busy = state != IDLE;
  assign done = state == FIN;
  assign mem_address = address;
  assign mem_byteenable = '1;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      address <= '0;
      words <= '0;
      max_lat <= '0;
      record_count <= '0;
      fail_count <= '0;
      end_marker <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          address <= base_addr;
          max_lat <= max_records;
          record_count <= '0;
          fail_count <= '0;
          end_marker <= 1'b0;
          state <= max_records == '0 ? FIN : RD_HI;
        end
        RD_HI: if (rd_done) begin
          if (abort) state <= FIN;
          else begin
            words[0] <= mem_readdata;
            address <= address + ADDR_WIDTH'(1);
            state <= RD_LO;
          end
        end
        RD_LO: if (rd_done) begin
          if (abort) state <= FIN;
          else begin
            words[1] <= mem_readdata;
            address <= address + ADDR_WIDTH'(1);
            state <= CHECK;
          end
        end
        CHECK: begin
          end_marker <= !abort && !run;
          state <= (abort || !run) ? FIN : PUSH;
        end
        PUSH: if (abort) state <= FIN;
        else if (!ofifo_full) begin
          record_count <= record_count + CNT_WIDTH'(1);
          fail_count <= fail_count + CNT_WIDTH'(fail);
          state <= record_count + CNT_WIDTH'(1) == max_lat ? FIN : RD_HI;
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_result_reader.sv
// tb_result_reader: directed and randomized readback runs against a record-walking reference model
module tb_result_reader;
  logic clock = 0, reset_n = 0, start = 0, abort = 0, ofifo_full = 0;
  logic [19:0] base_addr = 0;
  logic [15:0] max_records = 0;
  logic busy, done, end_marker, mem_read, ofifo_wrreq;
  logic [15:0] record_count, fail_count;
  logic [19:0] mem_address;
  logic [1:0] mem_byteenable;
  logic [15:0] mem_readdata = 0;
  logic mem_waitrequest = 0;
  logic [24:0] ofifo_data;
  int checks = 0, failures = 0;
  logic [15:0] mem [logic [19:0]];
  logic [24:0] got [$], exp_push [$];
  logic [19:0] reads [$], exp_reads [$];
  logic exp_end;
  int exp_rc, exp_fc, wait_n = 0, wcnt = 0, lat = 0;
  bit fresh = 1, hold = 0;
  logic [19:0] addr_hold = 0;

  result_reader dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .base_addr(base_addr), .max_records(max_records), .busy(busy), .done(done),
    .end_marker(end_marker), .record_count(record_count), .fail_count(fail_count),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_read(mem_read),
    .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest),
    .ofifo_data(ofifo_data), .ofifo_wrreq(ofifo_wrreq), .ofifo_full(ofifo_full)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    checks++;
    assert (got_v === exp_v) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  function automatic logic [15:0] rd(input logic [19:0] a);
    return mem.exists(a) ? mem[a] : 16'h0;
  endfunction

  task automatic put_rec(input logic [19:0] a, input logic [23:0] rv, input logic f);
    mem[a] = rv[23:8];
    mem[a + 20'd1] = {rv[7:0], 1'b1, 6'b0, f};
  endtask

  // Reference: walk records until the limit or a word1 without the RUN flag
  task automatic model(input logic [19:0] base, input logic [15:0] maxr);
    logic [19:0] a;
    logic [15:0] w0, w1;
    a = base;
    exp_push.delete(); exp_reads.delete();
    exp_end = 0; exp_rc = 0; exp_fc = 0;
    while (exp_rc < int'(maxr)) begin
      w0 = rd(a);
      w1 = rd(a + 20'd1);
      exp_reads.push_back(a);
      exp_reads.push_back(a + 20'd1);
      a = a + 20'd2;
      if (!w1[7]) begin exp_end = 1; break; end
      exp_push.push_back({w1[0], w0, w1[15:8]});
      exp_rc++;
      if (w1[0]) exp_fc++;
    end
  endtask

  // Memory slave plus protocol monitor; everything it sees applies to the upcoming rising edge
  always @(negedge clock) begin
    if (hold) begin
      chk("rd_held", mem_read, 1);
      chk("addr_held", mem_address, addr_hold);
      hold = 0;
    end
    if (ofifo_wrreq) begin
      chk("wrreq_while_full", ofifo_full, 0);
      got.push_back(ofifo_data);
    end
    if (!mem_read) begin
      mem_waitrequest = 0;
      fresh = 1;
    end else begin
      if (fresh) begin
        wcnt = wait_n < 0 ? int'($urandom_range(0, 2)) : wait_n;
        fresh = 0;
      end
      if (wcnt > 0) begin
        mem_waitrequest = 1;
        wcnt--;
        hold = 1;
        addr_hold = mem_address;
      end else begin
        mem_waitrequest = 0;
        mem_readdata = rd(mem_address);
        reads.push_back(mem_address);
        fresh = 1;
      end
    end
  end

  task automatic pulse_start(input logic [19:0] base, input logic [15:0] maxr);
    got.delete(); reads.delete();
    @(posedge clock); #1;
    base_addr = base; max_records = maxr; start = 1;
    @(posedge clock); #1;
    start = 0;
  endtask

  task automatic wait_done(input string tag, input bit rnd, input int trig);
    bit ok = 0, trg = 0;
    int fh = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (done) begin ok = 1; lat = i; break; end
      @(posedge clock); #1;
      if (trig >= 0 && !trg && reads.size() == trig) begin fh = 5; trg = 1; end
      ofifo_full = fh > 0 ? 1'b1 : rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (fh > 0) fh--;
    end
    chk({tag, "_done"}, ok, 1);
    @(posedge clock); #1;
    ofifo_full = 0;
  endtask

  task automatic run_case(input string tag, input logic [19:0] base, input logic [15:0] maxr,
                          input int waits, input bit rnd, input int trig);
    model(base, maxr);
    wait_n = waits;
    pulse_start(base, maxr);
    wait_done(tag, rnd, trig);
    chk({tag, "_end"}, end_marker, exp_end);
    chk({tag, "_rc"}, record_count, exp_rc);
    chk({tag, "_fc"}, fail_count, exp_fc);
    chk({tag, "_npush"}, got.size(), exp_push.size());
    for (int i = 0; i < exp_push.size() && i < got.size(); i++) chk({tag, "_push"}, got[i], exp_push[i]);
    chk({tag, "_nread"}, reads.size(), exp_reads.size());
    for (int i = 0; i < exp_reads.size() && i < reads.size(); i++) chk({tag, "_raddr"}, reads[i], exp_reads[i]);
  endtask

  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_read", mem_read, 0);
    chk("rst_wrreq", ofifo_wrreq, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_rc", record_count, 0);
    chk("rst_be", mem_byteenable, 2'b11);
    repeat (2) @(posedge clock);
    #1 reset_n = 1;

    mem.delete();
    put_rec(20'h00100, 24'hABCDEF, 0);
    put_rec(20'h00102, 24'h123456, 1);
    put_rec(20'h00104, 24'h000001, 0);
    mem[20'h00106] = 16'h5555;
    mem[20'h00107] = 16'h0000;
    run_case("term", 20'h00100, 16'd10, 0, 0, -1);
    chk("term_p0", got.size() > 0 ? got[0] : 25'h0, 25'h0ABCDEF);
    chk("term_p1", got.size() > 1 ? got[1] : 25'h0, 25'h1123456);
    chk("term_end_const", end_marker, 1);

    run_case("limit", 20'h00100, 16'd2, 0, 0, -1);
    chk("limit_last_addr", reads.size() > 0 ? reads[$] : 20'h0, 20'h00103);

    run_case("wait_bp", 20'h00100, 16'd10, 3, 0, 2);

    mem.delete();
    put_rec(20'hFFFFE, 24'h0F0F0F, 1);
    run_case("wrap", 20'hFFFFE, 16'd5, 0, 0, -1);
    chk("wrap_addr", reads.size() > 2 ? reads[2] : 20'hFFFFF, 20'h00000);

    run_case("zero", 20'h00040, 16'd0, 0, 0, -1);
    chk("zero_lat", lat, 0);

    for (int r = 0; r < 8; r++) begin
      logic [19:0] b;
      int n;
      mem.delete();
      b = 20'($urandom);
      n = $urandom_range(0, 5);
      for (int k = 0; k < n; k++) put_rec(b + 20'(2 * k), 24'($urandom), 1'($urandom));
      run_case("rand", b, 16'($urandom_range(0, 7)), -1, 1, -1);
    end

    begin : abort_case
      bit seen = 0;
      mem.delete();
      put_rec(20'h00200, 24'h111111, 0);
      put_rec(20'h00202, 24'h222222, 0);
      wait_n = 3;
      pulse_start(20'h00200, 16'd10);
      for (int i = 0; i < 100; i++) begin
        @(negedge clock); #1;
        if (mem_read && mem_address == 20'h00201 && mem_waitrequest) begin seen = 1; break; end
      end
      chk("abort_rdlo_seen", seen, 1);
      @(posedge clock); #1 abort = 1;
      wait_done("abort", 0, -1);
      abort = 0;
      chk("abort_npush", got.size(), 0);
      chk("abort_end", end_marker, 0);
      chk("abort_last_read", reads.size() > 0 ? reads[$] : 20'h0, 20'h00201);
      chk("abort_idle", busy, 0);
    end

    begin : reset_case
      bit seen = 0;
      mem.delete();
      put_rec(20'h00300, 24'hA5A5A5, 1);
      put_rec(20'h00302, 24'h5A5A5A, 0);
      wait_n = 0;
      pulse_start(20'h00300, 16'd10);
      for (int i = 0; i < 100; i++) begin
        @(negedge clock); #1;
        if (got.size() == 1) begin seen = 1; break; end
      end
      chk("rst_first_push", seen, 1);
      @(posedge clock); #1 ofifo_full = 1;
      for (int i = 0; i < 100 && reads.size() < 4; i++) @(posedge clock);
      repeat (3) @(posedge clock);
      #1 chk("rst_pre_rc", record_count, 1);
      chk("rst_pre_busy", busy, 1);
      #2 reset_n = 0;
      #1;
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_done", done, 0);
      chk("rst_mid_read", mem_read, 0);
      chk("rst_mid_wrreq", ofifo_wrreq, 0);
      chk("rst_mid_rc", record_count, 0);
      chk("rst_mid_fc", fail_count, 0);
      chk("rst_mid_addr", mem_address, 0);
      chk("rst_mid_data", ofifo_data, 0);
      chk("rst_mid_end", end_marker, 0);
      @(posedge clock); #1 reset_n = 1; ofifo_full = 0;
    end

    repeat (2) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
